u2_to_zm_serial: RTL and testbench

- Sequential converter from two's complement (U2) to sign-magnitude (ZM). It is the reverse path of the ALU's ZM→U2 converter.
- It accepts one m-bit U2 operand over a valid/ready handshake and negates negative values bit-serially, LSB first, over m−1 cycles.
- It returns the ZM result with the ALU's standard 4-bit status word.
- It sits between the U2 datapath and the ZM arithmetic operations (subtract, compare, bit-clear).

---
 rtl/alu_pkg.sv | 22 ++
 rtl/status_flags.sv | 25 ++
 rtl/u2_to_zm_serial.sv | 119 +++++++++++
 tb/tb_u2_to_zm_serial.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: converter state encoding and the
//               bit positions of the 4-bit status word.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ST_ERR    = 0;
    localparam int ST_SIGN   = 1;
    localparam int ST_PARITY = 2;
    localparam int ST_ONES   = 3;

endpackage
`default_nettype wire

// File: rtl/status_flags.sv
`default_nettype none
// ============================================================================
// Module      : status_flags
// Description : Combinational sign/parity/all-ones flags for an M-bit result.
//               The error bit is always 0 here; the parent owns it.
// Revision    : 1.0 - initial release
// ============================================================================
module status_flags
    import alu_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] i_value,
    output logic [3:0]   o_flags
);

    always_comb begin
        o_flags            = 4'b0000;
        o_flags[ST_SIGN]   = i_value[M-1];
        o_flags[ST_PARITY] = ~(^i_value);
        o_flags[ST_ONES]   = &i_value;
    end

endmodule
`default_nettype wire

// File: rtl/u2_to_zm_serial.sv
`default_nettype none
// ============================================================================
// Module      : u2_to_zm_serial
// Description : Bit-serial two's complement to sign-magnitude converter with
//               valid/ready handshakes and ALU status word.
// Revision    : 1.0 - initial release
// ============================================================================
module u2_to_zm_serial
    import alu_pkg::*;
#(
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [M-1:0] i_argA,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int             CW     = (M > 2) ? $clog2(M) : 1;
    localparam logic [CW-1:0]  c_last = CW'(M - 2);

    state_t          r_state;
    logic            r_sign;
    logic            r_err;
    logic            r_seen;
    logic [M-2:0]    r_sr;
    logic [M-2:0]    r_rr;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic [M-1:0]    r_result;
    logic [3:0]      r_status;

    logic            w_b;
    logic            w_obit;
    logic [M-2:0]    w_rr_next;
    logic [M-1:0]    w_res;
    logic [3:0]      w_flags;
    logic            w_is_min;

    // Copy bits up to and including the first one, invert the rest.
    always_comb begin
        w_b               = r_sr[0];
        w_obit            = (r_sign && r_seen) ? ~w_b : w_b;
        w_rr_next         = r_rr >> 1;
        w_rr_next[M-2]    = w_obit;
        w_res             = {r_sign, w_rr_next};
        w_is_min          = (i_argA == {1'b1, {(M-1){1'b0}}});
    end

    status_flags #(.M(M)) u_status_flags (
        .i_value (w_res),
        .o_flags (w_flags)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
            r_seen   <= 1'b0;
            r_sr     <= '0;
            r_rr     <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_status <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_sign  <= i_argA[M-1];
                        r_sr    <= i_argA[M-2:0];
                        r_err   <= w_is_min;
                        r_rr    <= '0;
                        r_seen  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_sr   <= r_sr >> 1;
                    r_rr   <= w_rr_next;
                    r_seen <= r_seen | w_b;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        if (r_err) begin
                            r_result <= '0;
                            r_status <= 4'b0001;
                        end else begin
                            r_result <= w_res;
                            r_status <= w_flags;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready  = (r_state == IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_u2_to_zm_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_u2_to_zm_serial
// Description : Directed and randomized bench for the U2 to ZM converter, M=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u2_to_zm_serial;

    logic       i_clk;
    logic       i_rstn;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_argA;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_result;
    logic [3:0] o_status;

    int n_vec;
    int n_fail;
    bit r_watch;
    bit r_seen_valid;

    u2_to_zm_serial #(.M(4)) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_argA   (i_argA),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_status (o_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge o_valid) if (r_watch) r_seen_valid = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed value -> |v| with sign bit, flags from bit counting.
    task automatic model(input logic [3:0] a, output logic [3:0] r, output logic [3:0] st);
        int v, mag, ones;
        v = a[3] ? int'(a) - 16 : int'(a);
        if (v == -8) begin
            r  = 4'd0;
            st = 4'b0001;
        end else begin
            mag  = (v < 0) ? -v : v;
            r    = 4'(((v < 0) ? 8 : 0) + mag);
            ones = 0;
            for (int k = 0; k < 4; k++) ones += int'(r[k]);
            st = {(r == 4'hF), (ones % 2 == 0), r[3], 1'b0};
        end
    endtask

    task automatic run_op(input logic [3:0] a, input int hold, input bit poke);
        logic [3:0] er, es;
        int lat;
        model(a, er, es);
        @(negedge i_clk);
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_argA  = a;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_argA  = 4'($urandom);
        lat = 0;
        while (!o_valid && lat < 10) begin
            if (poke && lat == 1) begin
                i_valid = 1'b1;
                i_argA  = ~a;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge i_clk);
            #1;
            lat++;
        end
        i_valid = 1'b0;
        check("latency", 32'(lat), 32'd3);
        check("result", 32'(o_result), 32'(er));
        check("status", 32'(o_status), 32'(es));
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk);
            #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_ready", 32'(o_ready), 32'd0);
            check("hold_result", 32'({o_result, o_status}), 32'({er, es}));
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check("valid_cleared", 32'(o_valid), 32'd0);
        check("ready_after", 32'(o_ready), 32'd1);
        check("result_kept", 32'({o_result, o_status}), 32'({er, es}));
    endtask

    initial begin
        n_vec        = 0;
        n_fail       = 0;
        r_watch      = 1'b0;
        r_seen_valid = 1'b0;
        i_rstn       = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_argA       = 4'd0;
        #12;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_status", 32'(o_status), 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        run_op(4'b0011, 0, 1'b0);
        run_op(4'b1101, 0, 1'b0);
        run_op(4'b1000, 0, 1'b0);
        run_op(4'b1001, 1, 1'b0);
        run_op(4'b1111, 0, 1'b0);
        run_op(4'b0000, 0, 1'b0);
        run_op(4'b0110, 5, 1'b1);

        // Abort mid-conversion; no result may appear afterwards.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_argA  = 4'b1010;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        r_watch = 1'b1;
        @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_outs", 32'({o_result, o_status}), 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;
        check("abort_no_valid", 32'(r_seen_valid), 32'd0);
        r_watch = 1'b0;
        run_op(4'b1010, 0, 1'b0);

        for (int n = 0; n < 30; n++)
            run_op(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
